// File: rtl/char_dec_pkg.sv
// Shared types and constants for the character-class block decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, byte width, default class count, case-fold helper
// used when CHAR_CASE_FOLD_EN is defined.
package char_dec_pkg;

   localparam int CHAR_W          = 8;
   localparam int DEF_NUM_CLASSES = 26;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SOD    = 2'd1,
      STREAM = 2'd2
   } dec_state_e;

   // ASCII 'A'..'Z' -> 'a'..'z'; every other byte passes through untouched.
   function automatic logic [CHAR_W-1:0] fold_case(input logic [CHAR_W-1:0] b);
      if (b >= 8'h41 && b <= 8'h5A) begin
         return b | 8'h20;
      end
      return b;
   endfunction

endpackage

// File: rtl/char_class_ram.sv
// Byte-indexed class-membership table, 256 entries x DATA_W bits.
// Latency: 1 cycle, registered read; a same-cycle write/read to one address returns the old entry.
// Backpressure: none, one write and one read may be issued every cycle.
//
// Ports: clk; wr_en/wr_addr/wr_data synchronous write; rd_addr in, rd_data out
// (registered). Contents are not reset and must be loaded after power-up.
module char_class_ram
   import char_dec_pkg::*;
#(
   parameter int DATA_W = DEF_NUM_CLASSES
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [CHAR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [CHAR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [0:(1<<CHAR_W)-1];
   logic [DATA_W-1:0] rd_data_d;
   logic [DATA_W-1:0] rd_data_q;

   always_comb begin
      rd_data_d = mem_q[rd_addr];
   end

   // The read samples the array before this edge's write lands, giving read-old behaviour.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/char_block_decoder.sv
// Packet byte stream -> per-class match lines, engine step enable and start-of-data pulse.
// Latency: 1 cycle from an accepted byte to en/char_lines; sod occupies one cycle after a sop.
// Backpressure: in_ready drops for a sop byte that opens a packet and during the SOD cycle.
//
// Ports: clk, rst (async, active-high); in_data/in_valid/in_sop/in_eop/in_ready
// stream input; cfg_we/cfg_addr/cfg_data class-table write (honoured in IDLE only);
// sod, en, char_lines engine outputs; byte_cnt saturating packet byte count;
// err sticky protocol/config error.
// Optional macro CHAR_CASE_FOLD_EN folds 'A'..'Z' to lowercase on both lookup and write.
module char_block_decoder
   import char_dec_pkg::*;
#(
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CHAR_W-1:0]      in_data,
   input  logic                   in_valid,
   input  logic                   in_sop,
   input  logic                   in_eop,
   output logic                   in_ready,
   input  logic                   cfg_we,
   input  logic [CHAR_W-1:0]      cfg_addr,
   input  logic [NUM_CLASSES-1:0] cfg_data,
   output logic                   sod,
   output logic                   en,
   output logic [NUM_CLASSES-1:0] char_lines,
   output logic [CNT_W-1:0]       byte_cnt,
   output logic                   err
);

   dec_state_e             state_q, state_d;
   logic                   en_q, en_d;
   logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
   logic                   err_q, err_d;
   logic                   pkt_started;
   logic                   tbl_we;
   logic [CHAR_W-1:0]      rd_addr;
   logic [CHAR_W-1:0]      wr_addr;
   logic [NUM_CLASSES-1:0] rd_data;

`ifdef CHAR_CASE_FOLD_EN
   assign rd_addr = fold_case(in_data);
   assign wr_addr = fold_case(cfg_addr);
`else
   assign rd_addr = in_data;
   assign wr_addr = cfg_addr;
`endif

   assign tbl_we = cfg_we & (state_q == IDLE);

   char_class_ram #(
      .DATA_W (NUM_CLASSES)
   ) u_ram (
      .clk     (clk),
      .wr_en   (tbl_we),
      .wr_addr (wr_addr),
      .wr_data (cfg_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         en_q       <= 1'b0;
         byte_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         byte_cnt_q <= byte_cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      en_d        = 1'b0;
      byte_cnt_d  = byte_cnt_q;
      err_d       = err_q;
      in_ready    = 1'b0;
      sod         = 1'b0;
      pkt_started = 1'b0;

      case (state_q)
         IDLE: begin
            // Non-sop bytes are swallowed; a sop byte is held until after SOD.
            in_ready = ~in_sop;
            if (in_valid && in_sop) begin
               state_d    = SOD;
               byte_cnt_d = '0;
            end
         end

         SOD: begin
            sod        = 1'b1;
            byte_cnt_d = '0;
            state_d    = STREAM;
         end

         STREAM: begin
            // A zero count means the packet's own sop byte is still pending;
            // only a sop arriving after data has flowed starts a new packet.
            pkt_started = (byte_cnt_q != '0);
            in_ready    = ~(in_sop & pkt_started);
            if (in_valid && in_sop && pkt_started) begin
               err_d      = 1'b1;
               byte_cnt_d = '0;
               state_d    = SOD;
            end else if (in_valid) begin
               en_d = 1'b1;
               if (byte_cnt_q != '1) begin
                  byte_cnt_d = byte_cnt_q + CNT_W'(1);
               end
               if (in_eop) begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      if (cfg_we && (state_q != IDLE)) begin
         err_d = 1'b1;
      end
   end

   assign en         = en_q;
   assign char_lines = en_q ? rd_data : '0;
   assign byte_cnt   = byte_cnt_q;
   assign err        = err_q;

endmodule

// File: tb/tb_char_block_decoder.sv
module tb_char_block_decoder;

   localparam int NC     = 26;
   localparam int CW     = 16;
   localparam int CNTMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_sop;
   logic          in_eop;
   logic          in_ready;
   logic          cfg_we;
   logic [7:0]    cfg_addr;
   logic [NC-1:0] cfg_data;
   logic          sod;
   logic          en;
   logic [NC-1:0] char_lines;
   logic [CW-1:0] byte_cnt;
   logic          err;

   char_block_decoder #(
      .NUM_CLASSES (NC),
      .CNT_W       (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .in_ready   (in_ready),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .sod        (sod),
      .en         (en),
      .char_lines (char_lines),
      .byte_cnt   (byte_cnt),
      .err        (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   bit chk_each = 1'b1;

   // Scoreboard entry: either a sod pulse or an en beat carrying class lines, due at cycle 'at'.
   typedef struct {
      bit            is_sod;
      logic [NC-1:0] val;
      int            at;
   } exp_t;
   exp_t expq[$];

   // Reference model: packet-level view of the decoder.
   logic [NC-1:0] m_tbl [256];
   bit            m_open;      // inside a packet, data may flow
   bit            m_sod_next;  // a start-of-data pulse is due this cycle
   bit            m_first;     // packet opened but its first byte not taken yet
   int            m_cnt;
   bit            m_err;

   function automatic logic [7:0] key(input logic [7:0] b);
`ifdef CHAR_CASE_FOLD_EN
      if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
`endif
      return b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents sod or en.
   exp_t e;
   always @(negedge clk) begin
      if (!rst) begin
         if (sod || en) begin
            checks++;
            if (sod && en) begin
               failures++;
               $display("FAIL sod_en_exclusive sod=%0b en=%0b cyc=%0d", sod, en, cyc);
            end else if (expq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output sod=%0b en=%0b lines=%0h cyc=%0d", sod, en, char_lines, cyc);
            end else begin
               e = expq.pop_front();
               if (e.is_sod != sod || e.at != cyc || (!e.is_sod && char_lines !== e.val)) begin
                  failures++;
                  $display("FAIL output_beat actual sod=%0b lines=%0h cyc=%0d expected sod=%0b lines=%0h cyc=%0d",
                           sod, char_lines, cyc, e.is_sod, e.val, e.at);
               end
            end
         end else begin
            checks++;
            if (char_lines != '0) begin
               failures++;
               $display("FAIL lines_idle actual=%0h expected=0 cyc=%0d", char_lines, cyc);
            end
            if (expq.size() != 0 && expq[0].at <= cyc) begin
               e = expq.pop_front();
               failures++;
               $display("FAIL missing_output actual=none expected sod=%0b lines=%0h cyc=%0d", e.is_sod, e.val, e.at);
            end
         end
      end
   end

   function automatic void push(input bit is_sod, input logic [NC-1:0] v);
      exp_t x;
      x.is_sod = is_sod;
      x.val    = v;
      x.at     = cyc + 1;
      expq.push_back(x);
   endfunction

   // One clock of stimulus; entered and left just after a falling edge.
   task automatic step(input bit v, input logic [7:0] d, input bit s, input bit eo,
                       input bit we, input logic [7:0] a, input logic [NC-1:0] cd,
                       output bit acc);
      bit exp_rdy;
      in_valid = v; in_data = d; in_sop = s; in_eop = eo;
      cfg_we = we; cfg_addr = a; cfg_data = cd;
      acc = 1'b0;
      if (m_sod_next)  exp_rdy = 1'b0;
      else if (s)      exp_rdy = m_open && m_first;
      else             exp_rdy = 1'b1;
      #1;
      if (chk_each) check("in_ready", in_ready, exp_rdy);
      if (m_sod_next) begin
         if (we) m_err = 1'b1;
         m_sod_next = 1'b0;
         m_open     = 1'b1;
         m_first    = 1'b1;
      end else if (m_open) begin
         if (we) m_err = 1'b1;
         if (v && s && !m_first) begin
            m_err = 1'b1; m_sod_next = 1'b1; m_open = 1'b0; m_cnt = 0;
            push(1'b1, '0);
         end else if (v) begin
            acc = 1'b1;
            push(1'b0, m_tbl[key(d)]);
            m_first = 1'b0;
            if (m_cnt < CNTMAX) m_cnt++;
            if (eo) m_open = 1'b0;
         end
      end else begin
         if (v && s) begin
            m_sod_next = 1'b1; m_cnt = 0;
            push(1'b1, '0);
         end else if (v) begin
            acc = 1'b1;
         end
         if (we) m_tbl[key(a)] = cd;
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      in_valid = 1'b0; cfg_we = 1'b0;
      if (chk_each) begin
         check("byte_cnt", byte_cnt, m_cnt);
         check("err", err, m_err);
      end
   endtask

   task automatic idle_cycle();
      bit acc;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, '0, acc);
   endtask

   // Present one byte and hold it until the model says it has been taken.
   task automatic send(input logic [7:0] d, input bit s, input bit eo);
      bit acc;
      acc = 1'b0;
      for (int t = 0; t < 4 && !acc; t++) step(1'b1, d, s, eo, 1'b0, 8'h00, '0, acc);
      if (!acc) begin
         checks++; failures++;
         $display("FAIL send_stall actual=not_taken expected=taken data=%0h", d);
      end
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [NC-1:0] cd);
      bit acc;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a, cd, acc);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; in_sop = 1'b1; in_eop = 1'b0;
      #1;
      check("rst_sod", sod, 1'b0);
      check("rst_en", en, 1'b0);
      check("rst_lines", char_lines, '0);
      check("rst_byte_cnt", byte_cnt, '0);
      check("rst_err", err, 1'b0);
      check("rst_ready_sop", in_ready, 1'b0);
      in_sop = 1'b0;
      #1;
      check("rst_ready_nosop", in_ready, 1'b1);
      m_open = 1'b0; m_sod_next = 1'b0; m_first = 1'b0; m_cnt = 0; m_err = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit            acc;
      logic [7:0]    d;
      int            len;
      in_data = '0; in_valid = 0; in_sop = 0; in_eop = 0;
      cfg_we = 0; cfg_addr = '0; cfg_data = '0;
      for (int i = 0; i < 256; i++) m_tbl[i] = '0;
      m_open = 0; m_sod_next = 0; m_first = 0; m_cnt = 0; m_err = 0;

      do_reset();

      // Load the whole table, then the entries the directed cases rely on.
      for (int i = 0; i < 256; i++) cfg_write(8'(i), NC'($urandom));
      cfg_write(8'h6C, NC'(1) << 15);
      cfg_write(8'h69, NC'(1) << 18);
`ifndef CHAR_CASE_FOLD_EN
      cfg_write(8'h4C, '0);
`endif

      // "li" packet: sod, then bit15, then bit18, count 2, back to IDLE.
      send(8'h6C, 1'b1, 1'b0);
      send(8'h69, 1'b0, 1'b1);
      check("li_byte_cnt", byte_cnt, 2);
      send(8'h33, 1'b0, 1'b0);   // IDLE swallows it without output

      // Uppercase lookup: folds to 'l' only when the feature is built in.
      send(8'h4C, 1'b1, 1'b1);
      idle_cycle();

      // Three non-sop bytes in IDLE.
      for (int i = 0; i < 3; i++) send(8'h41 + 8'(i), 1'b0, 1'b0);
      check("idle_drop_cnt", byte_cnt, 1);

      // Sop after five bytes: implicit end, error, byte held across SOD.
      send(8'h61, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send(8'h62 + 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h7A, 1'b1, 1'b0, 1'b0, 8'h00, '0, acc);
      check("sop_mid_taken", acc, 1'b0);
      check("sop_mid_err", err, 1'b1);
      send(8'h7A, 1'b1, 1'b0);
      check("restart_cnt", byte_cnt, 1);

      // Reset in the middle of that packet, then a plain byte must be dropped.
      do_reset();
      send(8'h6C, 1'b0, 1'b0);
      check("post_rst_err", err, 1'b0);

      // Table write during STREAM is refused and flagged.
      send(8'h69, 1'b1, 1'b0);
      step(1'b1, 8'h69, 1'b0, 1'b0, 1'b1, 8'h6C, NC'(1) << 3, acc);
      check("cfg_stream_err", err, 1'b1);
      send(8'h6C, 1'b0, 1'b1);

      // Random traffic.
      for (int p = 0; p < 200; p++) begin
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            case ($urandom_range(0, 2))
               0: idle_cycle();
               1: send(8'($urandom_range(0, 255)), 1'b0, 1'b0);
               default: cfg_write(8'($urandom_range(0, 255)), NC'($urandom));
            endcase
         end
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h41, 8'h7A)) : 8'($urandom_range(0, 255));
            if (b > 0 && $urandom_range(0, 3) == 0) idle_cycle();
            if (b > 0 && $urandom_range(0, 19) == 0)
               step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, d, NC'($urandom), acc);
            send(d, (b == 0) || ($urandom_range(0, 24) == 0), b == len - 1);
         end
      end

      // Long packet: counter must pin at its maximum.
      chk_each = 1'b0;
      send(8'h61, 1'b1, 1'b0);
      for (int i = 1; i < 70000; i++) send(8'($urandom_range(0, 255)), 1'b0, i == 69999);
      chk_each = 1'b1;
      check("byte_cnt_sat", byte_cnt, 16'hFFFF);
      idle_cycle();
      idle_cycle();
      check("scoreboard_empty", expq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
